// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse power-up sequencer: reset, IntelliMouse knock, ID read, stream enable.
// Latency: one command byte per SEND/TXWAIT/ACKWAIT round; stream_en rises on the final FA.
// Backpressure: tx_req is held with a stable tx_byte until tx_done/tx_err; every wait is bounded by TIMEOUT_CYC.
// Optional feature macro: PS2_WHEEL_EN (full knock + ID read); undefined gives FF, F4 only and wheel tied 0.
module ps2_mouse_init_ctrl #(
   parameter logic [25:0] TIMEOUT_CYC = 26'd50_000_000,
   parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       restart,
   output logic       tx_req,
   output logic [7:0] tx_byte,
   input  logic       tx_done,
   input  logic       tx_err,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       stream_en,
   output logic       wheel,
   output logic       err,
   output logic [1:0] retry_cnt
);

   typedef enum logic [3:0] {
      S_SEND,
      S_TXWAIT,
      S_ACKWAIT,
      S_BATWAIT,
      S_ID0WAIT,
`ifdef PS2_WHEEL_EN
      S_IDWAIT,
`endif
      S_DONE,
      S_FAIL,
      S_ERROR
   } state_t;

`ifdef PS2_WHEEL_EN
   localparam logic [3:0] LAST_STEP = 4'd8;
   localparam logic [3:0] ID_STEP   = 4'd7;
`else
   localparam logic [3:0] LAST_STEP = 4'd1;
`endif

   // Command bytes issued in order; step indexes this table.
   function automatic logic [7:0] step_rom(input logic [3:0] idx);
`ifdef PS2_WHEEL_EN
      case (idx)
         4'd0:    step_rom = 8'hFF;
         4'd1:    step_rom = 8'hF3;
         4'd2:    step_rom = 8'hC8;
         4'd3:    step_rom = 8'hF3;
         4'd4:    step_rom = 8'h64;
         4'd5:    step_rom = 8'hF3;
         4'd6:    step_rom = 8'h50;
         4'd7:    step_rom = 8'hF2;
         default: step_rom = 8'hF4;
      endcase
`else
      case (idx)
         4'd0:    step_rom = 8'hFF;
         default: step_rom = 8'hF4;
      endcase
`endif
   endfunction

   state_t      state;
   logic [3:0]  step;
   logic [25:0] timer;
   logic [1:0]  fe_cnt;
   logic        timeout;

`ifdef PS2_WHEEL_EN
   logic        wheel_q;
   assign wheel = wheel_q;
`else
   assign wheel = 1'b0;
`endif

   // Response window expires on the last counted cycle; an event in that cycle takes priority.
   assign timeout = (timer == TIMEOUT_CYC - 26'd1);

   // Sequencer: state, step pointer, timers, retry bookkeeping and all registered outputs.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state     <= S_SEND;
         step      <= 4'd0;
         timer     <= 26'd0;
         fe_cnt    <= 2'd0;
         tx_req    <= 1'b0;
         tx_byte   <= 8'h00;
         stream_en <= 1'b0;
         err       <= 1'b0;
         retry_cnt <= 2'd0;
`ifdef PS2_WHEEL_EN
         wheel_q   <= 1'b0;
`endif
      end else if (restart) begin
         // Abort from anywhere, including mid-transmission.
         state     <= S_SEND;
         step      <= 4'd0;
         timer     <= 26'd0;
         fe_cnt    <= 2'd0;
         tx_req    <= 1'b0;
         stream_en <= 1'b0;
         err       <= 1'b0;
         retry_cnt <= 2'd0;
`ifdef PS2_WHEEL_EN
         wheel_q   <= 1'b0;
`endif
      end else begin
         case (state)
            S_SEND: begin
               tx_byte <= step_rom(step);
               tx_req  <= 1'b1;
               timer   <= 26'd0;
               state   <= S_TXWAIT;
            end

            S_TXWAIT: begin
               if (tx_done) begin
                  tx_req <= 1'b0;
                  timer  <= 26'd0;
                  state  <= S_ACKWAIT;
               end else if (tx_err || timeout) begin
                  tx_req <= 1'b0;
                  timer  <= 26'd0;
                  state  <= S_FAIL;
               end else begin
                  timer <= timer + 26'd1;
               end
            end

            S_ACKWAIT: begin
               if (rx_valid) begin
                  timer <= 26'd0;
                  case (rx_byte)
                     8'hFA: begin
                        fe_cnt <= 2'd0;
                        if (step == 4'd0) begin
                           state <= S_BATWAIT;
`ifdef PS2_WHEEL_EN
                        end else if (step == ID_STEP) begin
                           state <= S_IDWAIT;
`endif
                        end else if (step == LAST_STEP) begin
                           state     <= S_DONE;
                           stream_en <= 1'b1;
                        end else begin
                           step  <= step + 4'd1;
                           state <= S_SEND;
                        end
                     end
                     8'hFE: begin
                        // Two resends of one step are tolerated; the third FE abandons the attempt.
                        if (fe_cnt == 2'd2) begin
                           fe_cnt <= 2'd0;
                           state  <= S_FAIL;
                        end else begin
                           fe_cnt <= fe_cnt + 2'd1;
                           state  <= S_SEND;
                        end
                     end
                     default: state <= S_FAIL;
                  endcase
               end else if (timeout) begin
                  timer <= 26'd0;
                  state <= S_FAIL;
               end else begin
                  timer <= timer + 26'd1;
               end
            end

            S_BATWAIT: begin
               if (rx_valid) begin
                  timer <= 26'd0;
                  state <= (rx_byte == 8'hAA) ? S_ID0WAIT : S_FAIL;
               end else if (timeout) begin
                  timer <= 26'd0;
                  state <= S_FAIL;
               end else begin
                  timer <= timer + 26'd1;
               end
            end

            S_ID0WAIT: begin
               // Post-BAT ID byte is normally 00 but its value does not matter here.
               if (rx_valid) begin
                  timer <= 26'd0;
                  step  <= 4'd1;
                  state <= S_SEND;
               end else if (timeout) begin
                  timer <= 26'd0;
                  state <= S_FAIL;
               end else begin
                  timer <= timer + 26'd1;
               end
            end

`ifdef PS2_WHEEL_EN
            S_IDWAIT: begin
               if (rx_valid) begin
                  timer   <= 26'd0;
                  wheel_q <= (rx_byte == 8'h03);
                  step    <= LAST_STEP;
                  state   <= S_SEND;
               end else if (timeout) begin
                  timer <= 26'd0;
                  state <= S_FAIL;
               end else begin
                  timer <= timer + 26'd1;
               end
            end
`endif

            S_DONE: begin
               // Packet traffic belongs to the decoder now; nothing here reacts to rx.
               timer <= 26'd0;
            end

            S_FAIL: begin
               timer  <= 26'd0;
               fe_cnt <= 2'd0;
               tx_req <= 1'b0;
               if (retry_cnt == MAX_RETRY - 2'd1) begin
                  retry_cnt <= MAX_RETRY;
                  err       <= 1'b1;
                  state     <= S_ERROR;
               end else begin
                  retry_cnt <= retry_cnt + 2'd1;
                  step      <= 4'd0;
`ifdef PS2_WHEEL_EN
                  wheel_q   <= 1'b0;
`endif
                  state     <= S_SEND;
               end
            end

            S_ERROR: begin
               tx_req <= 1'b0;
               timer  <= 26'd0;
            end

            default: begin
               tx_req <= 1'b0;
               timer  <= 26'd0;
               state  <= S_SEND;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed-random bench: a behavioural mouse answers the controller and a reference of the
// command list, retry counting and timeout timing predicts every observed output.
module tb_ps2_mouse_init_ctrl;

`ifdef PS2_WHEEL_EN
   localparam bit WHEEL = 1'b1;
   localparam int LAST  = 8;
`else
   localparam bit WHEEL = 1'b0;
   localparam int LAST  = 1;
`endif
   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       RESET = 1'b0;
   logic       restart = 1'b0;
   logic       tx_req;
   logic [7:0] tx_byte;
   logic       tx_done = 1'b0;
   logic       tx_err = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       stream_en;
   logic       wheel;
   logic       err;
   logic [1:0] retry_cnt;

   int total = 0;
   int bad = 0;

   ps2_mouse_init_ctrl #(.TIMEOUT_CYC(26'd100), .MAX_RETRY(2'd3)) dut (
      .CLOCK(clk), .RESET(RESET), .restart(restart),
      .tx_req(tx_req), .tx_byte(tx_byte), .tx_done(tx_done), .tx_err(tx_err),
      .rx_valid(rx_valid), .rx_byte(rx_byte),
      .stream_en(stream_en), .wheel(wheel), .err(err), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   // Command list the mouse should see, in order.
   function automatic logic [7:0] rom_b(input int i);
      logic [7:0] tbl [0:8];
      tbl = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
      if (!WHEEL) return (i == 0) ? 8'hFF : 8'hF4;
      return tbl[i];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for a transmit request, check its byte, optionally complete it after a random delay.
   task automatic tx_check(input logic [7:0] b, input bit ack);
      int k = 0;
      while (tx_req !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      total++;
      assert (k < 200) else begin
         bad++;
         $error("FAIL tx_req_wait: observed=no request expected=request for %0h", b);
      end
      chk("tx_byte", 32'(tx_byte), 32'(b));
      if (ack) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         tx_done = 1'b1;
         @(posedge clk);
         @(negedge clk);
         tx_done = 1'b0;
      end
   endtask

   task automatic rx_send(input logic [7:0] b);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge clk);
      @(negedge clk);
      restart = 1'b0;
   endtask

   // Behavioural mouse: walks the command list from 'start', answering FE fe_n times at
   // fe_step, and stops holding the request at stop_at. Returns early after a third FE.
   task automatic run_seq(input logic [7:0] id, input int fe_step, input int fe_n,
                          input int stop_at, input int start);
      for (int i = start; i <= LAST; i++) begin
         int n;
         if (i == stop_at) begin
            tx_check(rom_b(i), 1'b0);
            return;
         end
         n = (i == fe_step) ? fe_n : 0;
         for (int j = 0; j < n && j < 3; j++) begin
            tx_check(rom_b(i), 1'b1);
            rx_send(8'hFE);
         end
         if (n >= 3) return;
         tx_check(rom_b(i), 1'b1);
         rx_send(8'hFA);
         if (i == 0) begin
            rx_send(8'hAA);
            rx_send(8'($urandom_range(0, 255)));
         end
         if (WHEEL && i == 7) rx_send(id);
      end
   endtask

   task automatic chk_done(input string tag, input bit exp_wheel, input int exp_retry);
      chk({tag, "_stream_en"}, 32'(stream_en), 32'd1);
      chk({tag, "_wheel"}, 32'(wheel), 32'(exp_wheel));
      chk({tag, "_retry"}, 32'(retry_cnt), 32'(exp_retry));
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_tx_req"}, 32'(tx_req), 32'd0);
   endtask

   initial begin
      logic [7:0] id;
      int         s;

      // Reset values while RESET is held low.
      repeat (3) @(negedge clk);
      chk("rst_tx_req", 32'(tx_req), 32'd0);
      chk("rst_tx_byte", 32'(tx_byte), 32'd0);
      chk("rst_stream_en", 32'(stream_en), 32'd0);
      chk("rst_wheel", 32'(wheel), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_retry", 32'(retry_cnt), 32'd0);
      RESET = 1'b1;

      // Nominal bring-up with a wheel mouse.
      run_seq(8'h03, -1, 0, 99, 0);
      chk_done("nominal", WHEEL, 0);
      for (int i = 0; i < 3; i++) rx_send(8'($urandom_range(0, 255)));
      chk("done_ignores_rx", 32'(stream_en), 32'd1);
      chk("done_no_tx", 32'(tx_req), 32'd0);

      // Plain mouse ID: leaving DONE drops stream_en at once.
      pulse_restart();
      chk("restart_stream_en", 32'(stream_en), 32'd0);
      chk("restart_wheel", 32'(wheel), 32'd0);
      id = 8'($urandom_range(0, 255));
      if (id == 8'h03) id = 8'h00;
      run_seq(id, -1, 0, 99, 0);
      chk_done("plain_id", 1'b0, 0);

      // One or two FEs at a random step are resent without a retry.
      pulse_restart();
      s = $urandom_range(0, LAST);
      run_seq(8'h03, s, $urandom_range(1, 2), 99, 0);
      chk_done("fe_resend", WHEEL, 0);

      // Third consecutive FE abandons the attempt and starts over from FF.
      pulse_restart();
      s = $urandom_range(0, LAST);
      run_seq(8'h03, s, 3, 99, 0);
      @(negedge clk);
      chk("fe3_retry", 32'(retry_cnt), 32'd1);
      run_seq(8'h03, -1, 0, 99, 0);
      chk_done("fe3_recover", WHEEL, 1);

      // Silent mouse: each FF gets no answer; FAIL lands on the 100th ACKWAIT cycle.
      pulse_restart();
      for (int a = 0; a < 3; a++) begin
         tx_check(8'hFF, 1'b1);
         repeat (TO - 1) @(negedge clk);
         chk("to_before", 32'(retry_cnt), 32'(a));
         @(negedge clk);
         chk("to_fail_cycle", 32'(retry_cnt), 32'(a));
         @(negedge clk);
         chk("to_retry", 32'(retry_cnt), 32'(a + 1));
         chk("to_err", 32'(err), 32'(a == 2));
      end
      repeat (300) @(negedge clk);
      chk("error_err", 32'(err), 32'd1);
      chk("error_retry", 32'(retry_cnt), 32'd3);
      chk("error_tx_req", 32'(tx_req), 32'd0);
      pulse_restart();
      chk("error_restart_retry", 32'(retry_cnt), 32'd0);
      chk("error_restart_err", 32'(err), 32'd0);

      // FA arriving in exactly the timeout cycle is accepted.
      tx_check(8'hFF, 1'b1);
      repeat (TO - 1) @(negedge clk);
      rx_byte  = 8'hFA;
      rx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_send(8'hAA);
      rx_send(8'h00);
      run_seq(8'h03, -1, 0, 99, 1);
      chk_done("edge_fa", WHEEL, 0);

      // restart while a command is being transmitted.
      pulse_restart();
      s = (LAST < 4) ? LAST : 4;
      run_seq(8'h03, -1, 0, s, 0);
      chk("midtx_req_high", 32'(tx_req), 32'd1);
      pulse_restart();
      chk("midtx_req_drop", 32'(tx_req), 32'd0);
      run_seq(8'h00, -1, 0, 99, 0);
      chk_done("midtx_recover", 1'b0, 0);

      // Asynchronous RESET during BATWAIT.
      pulse_restart();
      tx_check(8'hFF, 1'b1);
      rx_send(8'hFA);
      #2;
      RESET = 1'b0;
      #1;
      chk("arst_tx_req", 32'(tx_req), 32'd0);
      chk("arst_tx_byte", 32'(tx_byte), 32'd0);
      chk("arst_stream_en", 32'(stream_en), 32'd0);
      chk("arst_retry", 32'(retry_cnt), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      @(negedge clk);
      RESET = 1'b1;
      run_seq(8'h03, -1, 0, 99, 0);
      chk_done("arst_recover", WHEEL, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
